// File: rtl/mmio_test_controller_pkg.sv
// Shared types and constants for the MMIO test controller.
// Test states, store-size codes and default register addresses.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_e;

  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  localparam logic [31:0] TOHOST_ADDR_DEF  = 32'h0000_1000;
  localparam logic [31:0] LED_ADDR_DEF     = 32'h0000_2000;
  localparam logic [31:0] CYCLE_ADDR_DEF   = 32'h0000_2004;
  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h0000_2008;

  // Counter step that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mmio_test_controller_if.sv
// CPU data-memory bus as seen by the MMIO test controller.
// The CPU is the master; the controller answers hit and read data.
interface mmio_test_controller_if;

  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [2:0]  dmem_funct3;
  logic        mmio_hit;
  logic [31:0] mmio_rdata;

  modport master (
    output dmem_addr,
    output dmem_wdata,
    output dmem_we,
    output dmem_funct3,
    input  mmio_hit,
    input  mmio_rdata
  );

  modport slave (
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_we,
    input  dmem_funct3,
    output mmio_hit,
    output mmio_rdata
  );

endinterface

// File: rtl/mmio_test_controller_console_fifo.sv
// Small synchronous FIFO buffering console bytes.
// A push while full is dropped unless a pop frees a slot that cycle.
module console_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  assign dout_o = mem_q[rd_q[AW-1:0]];

  // Pointer update; the extra MSB tells full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + ONE;
      if (pop_ok)  rd_q <= rd_q + ONE;
    end
  end

  // Storage write; contents need no reset since pointers gate them.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/mmio_test_controller.sv
// MMIO test controller: tohost pass/fail, watchdog, LEDs, cycle counter.
// Console FIFO at CONSOLE_ADDR is built only with MMIO_CONSOLE_EN defined.
module mmio_test_controller
  import mmio_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEF,
  parameter logic [31:0] LED_ADDR       = LED_ADDR_DEF,
  parameter logic [31:0] CYCLE_ADDR     = CYCLE_ADDR_DEF,
  parameter logic [31:0] CONSOLE_ADDR   = CONSOLE_ADDR_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned CONSOLE_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  mmio_test_controller_if.slave bus,
  output logic [3:0]  leds_out,
  output logic        test_done,
  output logic        test_pass,
  output logic        test_timeout,
  output logic [30:0] fail_code,
  output logic [31:0] cycle_count
`ifdef MMIO_CONSOLE_EN
  ,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready
`endif
);

  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [2:0]  funct3;

  logic        hit_tohost;
  logic        hit_led;
  logic        hit_cycle;
  logic        hit_con;

  logic        led_wr;
  logic        tohost_wr;
  logic        pass_wr;
  logic        fail_wr;
  logic        wd_exp;

  state_e      state_q;
  logic [31:0] cycle_q;
  logic [3:0]  leds_q;
  logic [30:0] fail_q;
  logic        done_q;
  logic        pass_q;
  logic        tmo_q;
  logic [31:0] rdata;

  assign addr   = bus.dmem_addr;
  assign wdata  = bus.dmem_wdata;
  assign we     = bus.dmem_we;
  assign funct3 = bus.dmem_funct3;

  assign hit_tohost = (addr == TOHOST_ADDR);
  assign hit_led    = (addr == LED_ADDR);
  assign hit_cycle  = (addr == CYCLE_ADDR);
`ifdef MMIO_CONSOLE_EN
  assign hit_con    = (addr == CONSOLE_ADDR);
`else
  assign hit_con    = 1'b0;
`endif

  assign bus.mmio_hit = hit_tohost | hit_led | hit_cycle | hit_con;

  // Zero-latency load mux; unmapped addresses read as zero.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_cycle: rdata = cycle_q;
      hit_led:   rdata = {28'b0, leds_q};
      default:   ;
    endcase
  end

  assign bus.mmio_rdata = rdata;

  assign led_wr    = we && hit_led;
  assign tohost_wr = we && hit_tohost &&
                     (funct3 == FUNCT3_SW) && wdata[0];
  assign pass_wr   = tohost_wr && (wdata == 32'd1);
  assign fail_wr   = tohost_wr && (wdata != 32'd1);
  assign wd_exp    = WD_EN && (cycle_q == WD_LAST);

  // Test FSM: a tohost store beats the watchdog; end states hold until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cycle_q <= '0;
      leds_q  <= '0;
      fail_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      if (led_wr) leds_q <= wdata[3:0];
      unique case (state_q)
        ST_RUN: begin
          if (pass_wr) begin
            state_q <= ST_PASS;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else if (fail_wr) begin
            state_q <= ST_FAIL;
            done_q  <= 1'b1;
            fail_q  <= wdata[31:1];
          end else if (wd_exp) begin
            state_q <= ST_TIMEOUT;
            done_q  <= 1'b1;
            tmo_q   <= 1'b1;
          end else begin
            cycle_q <= sat_inc(cycle_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign leds_out     = leds_q;
  assign test_done    = done_q;
  assign test_pass    = pass_q;
  assign test_timeout = tmo_q;
  assign fail_code    = fail_q;
  assign cycle_count  = cycle_q;

`ifdef MMIO_CONSOLE_EN
  logic con_push;
  logic con_empty;
  logic con_full_unused;

  assign con_push = we && hit_con;

  console_fifo #(
    .DEPTH (CONSOLE_DEPTH),
    .WIDTH (8)
  ) u_console (
    .clk     (clk),
    .rst     (rst),
    .push_i  (con_push),
    .din_i   (wdata[7:0]),
    .pop_i   (console_ready),
    .dout_o  (console_data),
    .full_o  (con_full_unused),
    .empty_o (con_empty)
  );

  assign console_valid = !con_empty;
`else
  logic unused_cfg;
  assign unused_cfg = ^{CONSOLE_ADDR, 32'(CONSOLE_DEPTH)};
`endif

endmodule
